pcpu_pipe_ctrl: RTL

//  Central sequencer for the 5-stage PCPU pipeline (IF/ID/EX/MEM/WB). Runs the

---
 rtl/pcpu_pipe_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pcpu_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage PCPU: run/drain/halt control, EX branch
// resolution, load-use stall detection, PC/IF/ID/ID/EX controls and perf counters.
module pcpu_pipe_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DRAIN_N = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [4:0]       id_op,
  input  logic [2:0]       id_ra,
  input  logic             id_ra_use,
  input  logic [2:0]       id_rb,
  input  logic             id_rb_use,
  input  logic [4:0]       ex_op,
  input  logic [2:0]       ex_rd,
  input  logic             zf,
  input  logic             nf,
  input  logic             cf,
  output logic             pc_clr,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DCNT_W = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_LOAD = 5'b00010;
  localparam logic [4:0] OP_JUMP = 5'b11000;
  localparam logic [4:0] OP_JMPR = 5'b11001;
  localparam logic [4:0] OP_BZ   = 5'b11010;
  localparam logic [4:0] OP_BNZ  = 5'b11011;
  localparam logic [4:0] OP_BN   = 5'b11100;
  localparam logic [4:0] OP_BNN  = 5'b11101;
  localparam logic [4:0] OP_BC   = 5'b11110;
  localparam logic [4:0] OP_BNC  = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_DRAIN  = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t            state, state_nx;
  logic [DCNT_W-1:0] drain_cnt, drain_nx;
  logic              br_take, load_use, halt_id;
  logic              count_cyc, count_stall;

  // Branch resolution for the instruction currently in EX
  always_comb begin
    br_take = 1'b0;
    case (ex_op)
      OP_JUMP, OP_JMPR: br_take = 1'b1;
      OP_BZ:            br_take = zf;
      OP_BNZ:           br_take = ~zf;
      OP_BN:            br_take = nf;
      OP_BNN:           br_take = ~nf;
      OP_BC:            br_take = cf;
      OP_BNC:           br_take = ~cf;
      default:          br_take = 1'b0;
    endcase
  end

  assign load_use = (ex_op == OP_LOAD) &&
                    ((id_ra_use && (id_ra == ex_rd)) || (id_rb_use && (id_rb == ex_rd)));
  assign halt_id  = (id_op == OP_HALT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else if (enable) begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
    end
  end

  // Next state and pipe controls; priority is branch > HALT in ID > load-use
  always_comb begin
    state_nx    = state;
    drain_nx    = drain_cnt;
    pc_clr      = 1'b0;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    count_cyc   = 1'b0;
    count_stall = 1'b0;
    if (enable) begin
      case (state)
        S_IDLE, S_HALTED: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (start) begin
            pc_clr   = 1'b1;
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          count_cyc = 1'b1;
          if (br_take) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (halt_id) begin
            if_id_flush = 1'b1;
            state_nx    = S_DRAIN;
            drain_nx    = '0;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
            count_stall = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
        end
        S_DRAIN: begin
          count_cyc   = 1'b1;
          if_id_flush = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nx = S_HALTED;
            drain_nx = '0;
          end else begin
            drain_nx = drain_cnt + DCNT_W'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // pc_sel only steers the PC mux, so it follows the branch even while frozen
  assign pc_sel    = (state == S_RUN) && br_take;
  assign run_state = state;

  // Saturating perf counters, cleared on the PC-clear pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (enable) begin
      if (pc_clr) begin
        cyc_cnt   <= '0;
        stall_cnt <= '0;
      end else begin
        if (count_cyc && (cyc_cnt != CNT_MAX))
          cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (count_stall && (stall_cnt != CNT_MAX))
          stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
